mux41_rr: RTL

// Merge path paired with demux14: collects words from four lane inputs onto one

---
 rtl/mux41_rr.sv | 50 +++++
 1 files changed

// File: rtl/mux41_rr.sv
// mux41_rr: round-robin merge of four valid/ready lanes into one lane-tagged registered stream
module mux41_rr #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [4*W-1:0] d,
  input  logic [3:0]     v,
  output logic [3:0]     rdy,
  output logic [W-1:0]   y,
  output logic [1:0]     s,
  output logic           yv,
  input  logic           yr
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  logic [0:0] state;
  logic [1:0] ptr, g;
  logic       hit, slot_free, grant;
  // scan from the farthest lane back to ptr so the nearest requester wins
  always_comb begin
    g = ptr;
    hit = 1'b0;
    for (int i = 3; i >= 0; i--)
      if (v[ptr + 2'(i)]) begin
        g = ptr + 2'(i);
        hit = 1'b1;
      end
  end
  assign yv        = (state == FULL);
  assign slot_free = (state == EMPTY) | (yv & yr);
  assign grant     = en & slot_free & hit & ~rst;
  assign rdy       = grant ? 4'(1) << g : 4'b0000;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      y     <= '0;
      s     <= 2'b00;
      ptr   <= 2'b00;
    end else if (grant) begin
      state <= FULL;
      y     <= d[g*W +: W];
      s     <= g;
      ptr   <= g + 2'd1;
    end else if (yv & yr) begin
      state <= EMPTY;
    end
  end
endmodule
